// File: rtl/ser_frame_tx.sv
// Word-to-serial framer: start(0), WIDTH data bits, optional parity, stop(1); each bit DIV cycles.
// o0 is registered; start bit appears the cycle after the handshake. i0_ready is high only while idle.
module ser_frame_tx #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int LSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  output logic             i0_ready,
  output logic             o0,
  output logic             busy,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARBIT = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_cnt_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             par, par_n;
  logic             o0_n;
  logic             bit_end;

  assign bit_end  = (div_cnt == DIV_LAST);
  assign i0_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      o0      <= 1'b1;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      o0      <= o0_n;
    end
  end

  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    o0_n      = 1'b1;

    case (state)
      IDLE: begin
        div_cnt_n = '0;
        bit_cnt_n = '0;
        if (i0_valid) begin
          state_n = START;
          shreg_n = i0_data;
          par_n   = (^i0_data) ^ (PARITY == 2);
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          div_cnt_n = '0;
          bit_cnt_n = '0;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          div_cnt_n = '0;
          shreg_n   = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
          if (bit_cnt == BIT_LAST) begin
            state_n = (PARITY != 0) ? PARBIT : STOP;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      PARBIT: begin
        if (bit_end) begin
          state_n   = STOP;
          div_cnt_n = '0;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n   = IDLE;
          div_cnt_n = '0;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        div_cnt_n = '0;
      end
    endcase

    // o0 is a flop, so it is loaded with the line level belonging to the next state
    case (state_n)
      START:   o0_n = 1'b0;
      DATA:    o0_n = (LSB_FIRST != 0) ? shreg_n[0] : shreg_n[WIDTH-1];
      PARBIT:  o0_n = par_n;
      default: o0_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Scoreboard bench: four transmitter configurations, each with its own stimulus, frame model and monitor.
module tb_ser_frame_tx;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] fin = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: {o0, busy, done, i0_ready}
  localparam logic [3:0] IDLE_OBS = 4'b1001;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got o0/busy/done/rdy=%b expected %b", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for ready", nm);
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int W   = (g == 3) ? 1 : 4;
    localparam int D   = (g == 0 || g == 3) ? 1 : 2;
    localparam int P   = (g == 0) ? 0 : (g == 1) ? 1 : 2;
    localparam int LSB = (g == 2) ? 0 : 1;
    localparam int FLEN = (2 + W + ((P != 0) ? 1 : 0)) * D;

    logic         rst, vld, rdy, o0, busy, done;
    logic [W-1:0] dat;
    logic [3:0]   expq[$];
    bit           idle_now = 1'b1;

    ser_frame_tx #(.WIDTH(W), .DIV(D), .LSB_FIRST(LSB), .PARITY(P)) dut (
      .clk(clk), .rst(rst), .i0_data(dat), .i0_valid(vld),
      .i0_ready(rdy), .o0(o0), .busy(busy), .done(done)
    );

    // Reference: a transfer happens at an edge ending an idle cycle with valid high
    always @(posedge clk) begin
      if (!rst && idle_now && vld) begin
        automatic logic bits[$];
        automatic logic [W-1:0] w = dat;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[(LSB != 0) ? i : W-1-i]);
        if (P != 0) bits.push_back((^w) ^ (P == 2));
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
          for (int k = 0; k < D; k++)
            expq.push_back({bits[b], 1'b1, (b == bits.size()-1) && (k == D-1), 1'b0});
      end
    end

    always @(negedge clk) begin
      automatic logic [3:0] e;
      if (rst || expq.size() == 0) e = IDLE_OBS;
      else e = expq.pop_front();
      if (rst) expq.delete();
      idle_now = e[0];
      check($sformatf("inst%0d t=%0t", g, $time), {o0, busy, done, rdy}, e);
    end

    task automatic send(input logic [W-1:0] w, input bit hold);
      bit ok = 1'b0;
      vld = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (rdy) begin
          dat = w;
          @(posedge clk);
          #1;
          ok = 1'b1;
        end else begin
          dat = W'($urandom);
        end
      end
      if (!ok) timeout($sformatf("inst%0d send", g));
      if (!hold) vld = 1'b0;
      dat = W'($urandom);
    endtask

    task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    initial begin
      rst = 1'b1;
      vld = 1'b0;
      dat = '0;
      cycles(3);
      rst = 1'b0;
      cycles(20);
      // directed words from the plan
      case (g)
        0, 1:    send(W'(4'b1011), 1'b0);
        2:       send(W'(4'b0110), 1'b0);
        default: send(W'(1), 1'b0);
      endcase
      cycles(FLEN + 3);
      // back-to-back with valid held high
      send(W'(4'hA), 1'b1);
      send(W'(4'h5), 1'b0);
      cycles(FLEN + 3);
      // reset during the second data bit
      send(W'(4'b1101), 1'b0);
      cycles(2 * D);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(2);
      send(W'(4'b1001), 1'b0);
      cycles(FLEN + 3);
      // randomized traffic
      for (int n = 0; n < 30; n++) begin
        vld = 1'b0;
        cycles($urandom_range(0, 3));
        send(W'($urandom), 1'($urandom_range(0, 1)));
      end
      vld = 1'b0;
      cycles(FLEN + 5);
      fin[g] = 1'b1;
    end
  end

  initial begin
    bit all = 1'b0;
    for (int c = 0; c < 20000 && !all; c++) begin
      @(posedge clk);
      all = &fin;
    end
    if (!all) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end: stimulus did not complete, fin=%b required 1111", fin);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
